// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: issues sequential ROM reads under a credit limit and
// queues {address, instruction} pairs for the decode stage, with jump redirect.
module ifetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [31:0]   pc_reg, pc_next;
    logic          pending_reg, pending_next;
    logic [31:0]   req_addr_reg, req_addr_next;
    logic [31:0]   last_addr_reg, last_addr_next;

    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_inst [DEPTH];

    logic credit;
    logic issue;
    logic head_valid;
    logic push;
    logic pop;

    // Credit counts the in-flight response so a push can never land on a full FIFO.
    assign credit     = (count_reg + CW'(pending_reg)) < CW'(DEPTH);
    assign issue      = rst & (jump_en_i | credit);
    assign head_valid = (count_reg != '0);
    assign push       = pending_reg & ~jump_en_i;
    assign pop        = head_valid & inst_ready_i & ~jump_en_i;

    assign rom_req_o    = issue;
    assign rom_addr_o   = (rst & jump_en_i) ? jump_addr_i : pc_reg;
    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? mem_inst[rd_ptr_reg] : NOP_INST;
    assign inst_addr_o  = head_valid ? mem_addr[rd_ptr_reg] : last_addr_reg;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        pc_next        = pc_reg;
        pending_next   = issue;
        req_addr_next  = req_addr_reg;
        last_addr_next = last_addr_reg;
        if (jump_en_i) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            pc_next       = jump_addr_i + 32'd4;
            req_addr_next = jump_addr_i;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next    = rd_ptr_reg + 1'b1;
                last_addr_next = mem_addr[rd_ptr_reg];
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push) begin
                count_next = count_reg - 1'b1;
            end
            if (issue) begin
                pc_next       = pc_reg + 32'd4;
                req_addr_next = pc_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            pc_reg        <= RESET_PC;
            pending_reg   <= 1'b0;
            req_addr_reg  <= RESET_PC;
            last_addr_reg <= 32'h0000_0000;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            pc_reg        <= pc_next;
            pending_reg   <= pending_next;
            req_addr_reg  <= req_addr_next;
            last_addr_reg <= last_addr_next;
        end
    end

    // Storage carries no reset; head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_reg] <= req_addr_reg;
            mem_inst[wr_ptr_reg] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer; the ROM model returns word (addr >> 2).
module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_ready;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int nreq;

    always #5 clk = ~clk;

    ifetch_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .rom_req_o   (rom_req),
        .rom_addr_o  (rom_addr),
        .rom_inst_i  (rom_inst),
        .inst_valid_o(inst_valid),
        .inst_o      (inst),
        .inst_addr_o (inst_addr),
        .inst_ready_i(inst_ready)
    );

    // One-cycle ROM; garbage when not requested so an unwanted push is visible.
    always @(posedge clk) begin
        rom_inst <= rom_req ? (rom_addr >> 2) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic j, input logic [31:0] ja, input logic rdy);
        @(posedge clk);
        #1;
        jump_en    = j;
        jump_addr  = ja;
        inst_ready = rdy;
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(rom_req),    32'd0);
        chk({tag, "_raddr"}, rom_addr,        32'h0);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_inst"},  inst,            32'h13);
        chk({tag, "_iaddr"}, inst_addr,       32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; jump_en = 1'b0; jump_addr = '0; inst_ready = 1'b1;
        #2;
        chk_reset_outputs("rst");

        // Streaming with ready held high
        @(posedge clk); @(posedge clk); #1; rst = 1'b1; #1;
        chk("c0_req", 32'(rom_req), 32'd1);
        chk("c0_valid", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc(1'b0, 32'h0, 1'b1);
            chk($sformatf("stream_raddr%0d", k), rom_addr, 32'(4 * k));
            if (k == 1) chk("c1_valid", 32'(inst_valid), 32'd0);
            if (k >= 2) begin
                chk($sformatf("stream_iaddr%0d", k), inst_addr, 32'(4 * (k - 2)));
                chk($sformatf("stream_inst%0d", k), inst, 32'(k - 2));
            end
        end

        // Backpressure: exactly DEPTH requests, then contiguous drain
        #1; rst = 1'b0; inst_ready = 1'b0; #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1; rst = 1'b1; #1;
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc(1'b0, 32'h0, 1'b0);
            nreq += int'(rom_req);
            if (k >= 4) chk($sformatf("bp_noreq%0d", k), 32'(rom_req), 32'd0);
        end
        chk("bp_nreq", 32'(nreq), 32'd4);
        chk("bp_hold_inst", inst, 32'h0);
        chk("bp_hold_valid", 32'(inst_valid), 32'd1);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk($sformatf("drain_valid%0d", j), 32'(inst_valid), 32'd1);
            chk($sformatf("drain_iaddr%0d", j), inst_addr, 32'(4 * j));
            chk($sformatf("drain_inst%0d", j), inst, 32'(j));
        end

        // Jump with 3 entries buffered and a response in flight
        #1; rst = 1'b0; inst_ready = 1'b0; #1;
        @(posedge clk); #1; rst = 1'b1; #1;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 1'b1);
        chk("jmp_valid_before", 32'(inst_valid), 32'd1);
        chk("jmp_req", 32'(rom_req), 32'd1);
        chk("jmp_raddr", rom_addr, 32'h100);
        cyc(1'b0, 32'h0, 1'b1);
        chk("jmp1_valid", 32'(inst_valid), 32'd0);
        chk("jmp1_inst", inst, 32'h13);
        chk("jmp1_raddr", rom_addr, 32'h104);
        cyc(1'b0, 32'h0, 1'b1);
        chk("jmp2_valid", 32'(inst_valid), 32'd1);
        chk("jmp2_iaddr", inst_addr, 32'h100);
        chk("jmp2_inst", inst, 32'h40);
        cyc(1'b0, 32'h0, 1'b1);
        chk("jmp3_iaddr", inst_addr, 32'h104);
        chk("jmp3_inst", inst, 32'h41);

        // Back-to-back jumps: only the last target survives
        cyc(1'b1, 32'h40, 1'b1);
        chk("bb0_raddr", rom_addr, 32'h40);
        cyc(1'b1, 32'h80, 1'b1);
        chk("bb1_raddr", rom_addr, 32'h80);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bb2_valid", 32'(inst_valid), 32'd0);
        chk("bb2_lastaddr", inst_addr, 32'h104);
        cyc(1'b0, 32'h0, 1'b0);
        chk("bb3_iaddr", inst_addr, 32'h80);
        chk("bb3_inst", inst, 32'h20);

        // Fill to full, then asynchronous reset
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("full_noreq", 32'(rom_req), 32'd0);
        chk("full_iaddr", inst_addr, 32'h80);
        #1; rst = 1'b0; #1;
        chk_reset_outputs("fullrst");
        @(posedge clk); #1; rst = 1'b1; inst_ready = 1'b1; #1;
        chk("rr0_req", 32'(rom_req), 32'd1);
        chk("rr0_raddr", rom_addr, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("rr1_valid", 32'(inst_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("rr2_iaddr", inst_addr, 32'h0);
        chk("rr2_inst", inst, 32'h0);

        // PC wrap at the top of the address space
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_raddr", rom_addr, 32'hFFFF_FFFC);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_next_raddr", rom_addr, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_iaddr", inst_addr, 32'hFFFF_FFFC);
        chk("wrap_inst", inst, 32'h3FFF_FFFF);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_iaddr2", inst_addr, 32'h0);
        chk("wrap_inst2", inst, 32'h0);

        // Unaligned target passes through unchanged
        cyc(1'b1, 32'h102, 1'b1);
        chk("unal_raddr", rom_addr, 32'h102);
        cyc(1'b0, 32'h0, 1'b1);
        chk("unal_next_raddr", rom_addr, 32'h106);
        cyc(1'b0, 32'h0, 1'b1);
        chk("unal_iaddr", inst_addr, 32'h102);
        chk("unal_inst", inst, 32'h40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
